// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: func codes, FSM states,
// op-type encoding and the func-field decode helpers.
package mdu_pkg;

  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // bit 1 selects divide, bit 0 selects signed
  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIV  = 2'b11
  } op_e;

  function automatic logic is_mdop(input logic [5:0] f);
    return (f == FUNC_MULT) || (f == FUNC_MULTU) || (f == FUNC_DIV) || (f == FUNC_DIVU);
  endfunction

  function automatic op_e decode_op(input logic [5:0] f);
    op_e op;
    case (f)
      FUNC_MULT: op = OP_MUL;
      FUNC_DIV:  op = OP_DIV;
      FUNC_DIVU: op = OP_DIVU;
      default:   op = OP_MULU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// acc layout: multiply {partial[W:0], multiplier[W-1:0]}, divide {rem[W:0], quotient/dividend[W-1:0]}.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH:0]   acc_nxt
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH+1:0]   diff;

  always_comb begin
    sum     = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
    shifted = {acc[2*WIDTH-1:0], 1'b0};
    diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, opnd};
    acc_nxt = '0;
    if (!is_div) begin
      acc_nxt = {1'b0, sum, acc[WIDTH-1:1]};
    end else if (!diff[WIDTH+1]) begin
      // divisor fits: keep the difference and set the quotient bit
      acc_nxt = {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
    end else begin
      acc_nxt = shifted;
    end
  end

endmodule

// File: rtl/mdu_ctr.sv
// Iterative multiply/divide unit owning HI/LO: decodes the R-type MDU func group,
// runs WIDTH iterations on magnitudes, then fixes signs and writes HI/LO.
module mdu_ctr
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   acc, acc_step;
  logic [WIDTH-1:0]   opnd, a_keep;
  logic               is_div, neg_q, neg_r, b_zero;

  logic               accept, sgn;
  op_e                dec_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign busy = (state != ST_IDLE);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_step)
  );

  // flush wins over start, so a simultaneous request is dropped
  always_comb begin
    accept = start && !busy && !flush;
    dec_op = decode_op(func);
    sgn    = dec_op[0];
    a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
  end

  always_comb begin
    prod_fix = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mdop(func)) state_nxt = ST_RUN;
      ST_RUN: begin
        if (flush)                 state_nxt = ST_IDLE;
        else if (cnt == CNT_LAST)  state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      a_keep  <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      b_zero  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      dz      <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= 1'b0;
      dz      <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mdop(func)) begin
              // multiplicand / divisor stays in opnd; the other operand seeds acc
              cnt    <= '0;
              is_div <= dec_op[1];
              acc    <= {(WIDTH+1)'(0), dec_op[1] ? a_mag : b_mag};
              opnd   <= dec_op[1] ? b_mag : a_mag;
              a_keep <= a;
              neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r  <= sgn && a[WIDTH-1];
              b_zero <= (b == '0);
            end else if (func == FUNC_MTHI) begin
              hi   <= a;
              done <= 1'b1;
            end else if (func == FUNC_MTLO) begin
              lo   <= a;
              done <= 1'b1;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            cnt <= '0;
          end else begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_FIX: begin
          cnt <= '0;
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (b_zero) begin
              hi <= a_keep;
              lo <= '1;
              dz <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctr.sv
// Directed bench for mdu_ctr (WIDTH=32): vector table for the arithmetic,
// hand-written sequences for MT writes, ignored starts, flush, illegal and reset.
module tb_mdu_ctr;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [5:0]   func = 6'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         busy, done, dz, illegal;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int busy_bad = 0;
  int ill_seen = 0;

  typedef struct {
    string        name;
    logic [5:0]   func;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[9];

  mdu_ctr #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .func    (func),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .dz      (dz),
    .illegal (illegal),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (illegal) ill_seen++;
  endtask

  // Waits for done; lat is the number of edges from the call point, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (done) begin
        lat = k;
        return;
      end
      if (!busy) busy_bad++;
    end
  endtask

  task automatic run_op(input logic [5:0] f, input logic [W-1:0] va, input logic [W-1:0] vb,
                        output int lat);
    start = 1'b1;
    func  = f;
    a     = va;
    b     = vb;
    tick();
    start = 1'b0;
    if (!busy) busy_bad++;
    wait_done(lat);
  endtask

  initial begin
    int lat;
    int n_done;
    logic [W-1:0] hi_exp, lo_exp;

    vecs[0] = '{"multu_max",  6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{"mult_neg",   6'b011000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2] = '{"mult_negneg",6'b011000, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 1'b0};
    vecs[3] = '{"div_neg",    6'b011010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4] = '{"div_negdvs", 6'b011010, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0};
    vecs[5] = '{"divu_small", 6'b011011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[6] = '{"div_zero",   6'b011010, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[7] = '{"divu_zero",  6'b011011, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1'b1};
    vecs[8] = '{"div_ovf",    6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};

    // reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // arithmetic table; each next start lands in the previous done cycle
    foreach (vecs[i]) begin
      busy_bad = 0;
      run_op(vecs[i].func, vecs[i].a, vecs[i].b, lat);
      chk({vecs[i].name, "_lat"}, 64'(lat), 64'd33);
      chk({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].hi));
      chk({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].lo));
      chk({vecs[i].name, "_dz"}, 64'(dz), 64'(vecs[i].dz));
      chk({vecs[i].name, "_busy_done"}, 64'(busy), 64'd0);
      chk({vecs[i].name, "_busy_run"}, 64'(busy_bad), 64'd0);
    end
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("dz_one_cycle", 64'(dz), 64'd0);
    chk("no_illegal_table", 64'(ill_seen), 64'd0);

    // MTHI / MTLO
    start = 1'b1; func = 6'b010001; a = 32'hA5A5A5A5;
    tick();
    start = 1'b0;
    chk("mthi_hi", 64'(hi), 64'hA5A5A5A5);
    chk("mthi_lo_kept", 64'(lo), 64'h80000000);
    chk("mthi_done", 64'(done), 64'd1);
    chk("mthi_busy", 64'(busy), 64'd0);
    start = 1'b1; func = 6'b010011; a = 32'h0BADF00D;
    tick();
    start = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h0BADF00D);
    chk("mtlo_hi_kept", 64'(hi), 64'hA5A5A5A5);
    chk("mtlo_done", 64'(done), 64'd1);
    tick();
    chk("mt_done_pulse", 64'(done), 64'd0);

    // second start while busy is ignored
    ill_seen = 0;
    start = 1'b1; func = 6'b011001; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; func = 6'b011011; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    wait_done(lat);
    chk("busy_start_lat", 64'(lat + 5), 64'd33);
    chk("busy_start_hi", 64'(hi), 64'd0);
    chk("busy_start_lo", 64'(lo), 64'd12);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || busy) n_done++;
    end
    chk("busy_start_dropped", 64'(n_done), 64'd0);
    chk("busy_start_no_illegal", 64'(ill_seen), 64'd0);

    // flush at iteration 10
    start = 1'b1; func = 6'b011001; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    tick();
    start = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || dz) n_done++;
    end
    chk("flush_no_done", 64'(n_done), 64'd0);
    chk("flush_hi", 64'(hi), 64'd0);
    chk("flush_lo", 64'(lo), 64'd12);

    // unsupported func
    ill_seen = 0;
    start = 1'b1; func = 6'h20; a = 32'h11111111; b = 32'h22222222;
    tick();
    start = 1'b0;
    chk("illegal_pulse", 64'(illegal), 64'd1);
    chk("illegal_busy", 64'(busy), 64'd0);
    chk("illegal_done", 64'(done), 64'd0);
    tick();
    chk("illegal_one_cycle", 64'(illegal), 64'd0);
    chk("illegal_hi", 64'(hi), 64'd0);
    chk("illegal_lo", 64'(lo), 64'd12);

    // flush in the FIX cycle suppresses the write
    start = 1'b1; func = 6'b011011; a = 32'd7; b = 32'd2;
    tick();
    start = 1'b0;
    repeat (32) tick();
    chk("fix_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fix_flush_done", 64'(done), 64'd0);
    chk("fix_flush_busy", 64'(busy), 64'd0);
    chk("fix_flush_hi", 64'(hi), 64'd0);
    chk("fix_flush_lo", 64'(lo), 64'd12);

    // flush and start in the same idle cycle: start dropped
    start = 1'b1; flush = 1'b1; func = 6'b010011; a = 32'hDEADBEEF;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_done", 64'(done), 64'd0);
    chk("flush_start_lo", 64'(lo), 64'd12);

    // async reset mid-RUN
    start = 1'b1; func = 6'b010001; a = 32'h5A5A5A5A;
    tick();
    start = 1'b1; func = 6'b011001; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // recovery after reset
    busy_bad = 0;
    run_op(6'b011011, 32'd100, 32'd7, lat);
    hi_exp = 32'd2;
    lo_exp = 32'd14;
    chk("recover_lat", 64'(lat), 64'd33);
    chk("recover_hi", 64'(hi), 64'(hi_exp));
    chk("recover_lo", 64'(lo), 64'(lo_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctr.md
Name: mdu_ctr

Overview:
- Parametrised multiply/divide unit with its own func-field decoder for the MIPS R-type MULT/MULTU/DIV/DIVU/MTHI/MTLO group.
- Owns the HI/LO registers.
- Runs iterative shift-add multiply and restoring divide over WIDTH cycles, with a start/busy/done handshake the pipeline uses to stall MFHI/MFLO and further MDU ops.
- Sits beside the ALU and its control decoder in the EX stage.

Parameters:
- WIDTH, 32, operand/HI/LO width; legal range is WIDTH >= 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- func  in  6  R-type func field of the requesting instruction.
- a  in  WIDTH  rs operand (dividend / multiplicand / MT source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  synchronous cancel of an in-flight op.
- busy  out  1  high while an op is in flight; pipeline must stall MF/MDU ops.
- done  out  1  one-cycle pulse when HI/LO have been updated.
- dz  out  1  one-cycle pulse, coincident with done, on divide by zero.
- illegal  out  1  one-cycle pulse when start arrives with an unsupported func.
- hi  out  WIDTH  HI register (MFHI reads this directly).
- lo  out  WIDTH  LO register (MFLO reads this directly).

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, counter=0, hi=lo=0, busy=done=dz=illegal=0.
- Func codes:
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO.
  - Any other func with start=1 and busy=0 pulses illegal for 1 cycle the next cycle; no other effect.
- MTHI/MTLO: start sampled at edge E0 writes hi (or lo) := a at E0; done pulses during the following cycle; busy stays 0.
- FSM states:
  - IDLE -> RUN on start with a MULT/DIV func: latches operands, op type and signedness; busy=1 from E0.
  - RUN performs one iteration per edge E1..E_WIDTH; a counter counts 0..WIDTH-1.
  - RUN -> FIX after the last iteration.
  - FIX applies sign correction and writes hi/lo at E_(WIDTH+1); done=1 for that one cycle; busy=0.
  - FIX -> IDLE.
  - Latency from start edge to hi/lo valid is WIDTH+1 cycles; throughput is one op per WIDTH+2 cycles (a new start is accepted in the done cycle).
- Signed ops: operate on magnitudes and fix signs in FIX.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder takes the sign of the dividend.
- Multiply: {hi,lo} = full 2*WIDTH product.
- Divide: lo = quotient, hi = remainder.
- Divide by zero (b=0, signed or unsigned): hi := a, lo := all ones, dz pulses with done. The iteration still takes the full WIDTH cycles.
- Signed overflow, MIN / -1: lo := MIN (truncated), hi := 0, no dz.
- start while busy=1: ignored entirely, with no illegal pulse.
- flush=1 while busy: FSM returns to IDLE at the next edge; hi/lo unchanged; no done, no dz.
- flush=1 while idle: no effect.
- flush and start in the same cycle: flush wins and start is dropped.
- flush in the FIX cycle: hi/lo are NOT written.
- Internal accumulators are 2*WIDTH+1 bits wide; the counter is $clog2(WIDTH) bits.
- hi/lo only change on a done cycle, an MTHI/MTLO write, or reset.

Decomposition:
- Shared package mdu_pkg:
  - func code localparams (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
  - FSM state encoding (IDLE, RUN, FIX).
  - op-type encoding (MUL/DIV × signed/unsigned).
- One sub-module, mdu_step: combinational single iteration, either a shift-add step or a restoring-subtract step, selected by op type.
- mdu_ctr holds the FSM, counter, operand registers, sign fix and HI/LO.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 cycles; done exactly 33 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7 b=2 -> lo=3, hi=1.
- DIV a=0x00001234 b=0 -> hi=0x00001234, lo=0xFFFFFFFF, dz=1 together with done.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, dz=0.
- Control sequence:
  - MTHI a=0xA5A5A5A5 -> hi=0xA5A5A5A5 and done next cycle.
  - start MULTU, then a second start at cycle 5 -> second start ignored.
  - flush at iteration 10 -> hi/lo unchanged, no done.
  - start func=0x20 -> illegal pulse, hi/lo unchanged.
  - async rst asserted mid-RUN -> all outputs 0 immediately.
